// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, reset PC, NOP encoding and fetch FSM state type
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem req/rsp and decode valid/ready bundle; master = fetch side, slave = memory/decode side
interface fetch_stage_if #(
  parameter int XLEN = 32
) ();
  import fetch_stage_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instruction;
  logic [XLEN-1:0] if_pc;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
  );
endinterface

// File: rtl/fetch_stage_fifo.sv
// fetch_stage_fifo: sync FIFO (clk, rst, push/pop/flush, wdata -> rdata, count, full, empty); flush wins
module fetch_stage_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end
  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign full = count_q[AW];
  assign empty = count_q == '0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC + in-order imem fetch into buffer to decode, redirect flush/fault (clk, rst, bus, redirect_*, fetch_fault; FETCH_PERF_EN adds perf_fetched/perf_flushed)
module fetch_stage #(
  parameter int XLEN = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_stage_pkg::RESET_PC),
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  fetch_stage_if.master   bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);
  import fetch_stage_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pcq_head;
  logic [CW-1:0] drop_q, drop_d, pcq_count, ibuf_count, occ;
  logic [ILEN+XLEN-1:0] ibuf_head;
  logic accept, rsp_live, pop, ibuf_empty, ibuf_full, pcq_full, pcq_empty, unused_ok;
  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_live = bus.imem_rsp_valid && drop_q == '0 && !redirect_valid;
  assign pop = bus.if_valid && bus.if_ready;
  // Crediting this cycle's pop lets zero-wait memory sustain one instruction per cycle
  assign occ = drop_q + pcq_count + ibuf_count - CW'(pop);
  assign bus.imem_req_valid = !rst && state_q == RUN && !redirect_valid && occ < DEPTH_C;
  assign bus.imem_req_addr = pc_q;
  always_comb begin
    state_d = redirect_valid ? (|redirect_pc[1:0] ? FAULT : RUN) : state_q;
    pc_d = redirect_valid ? redirect_pc : accept ? pc_q + XLEN'(4) : pc_q;
    // Live in-flight requests become drops; a response landing now consumes one of them
    drop_d = redirect_valid ? drop_q + pcq_count - CW'(bus.imem_rsp_valid)
                            : drop_q - CW'(bus.imem_rsp_valid && drop_q != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
    end
  end
  fetch_stage_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_pcq (
    .clk(clk), .rst(rst), .push(accept), .pop(rsp_live), .flush(redirect_valid),
    .wdata(pc_q), .rdata(pcq_head), .count(pcq_count), .full(pcq_full), .empty(pcq_empty)
  );
  fetch_stage_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ILEN + XLEN)) u_ibuf (
    .clk(clk), .rst(rst), .push(rsp_live), .pop(pop), .flush(redirect_valid),
    .wdata({bus.imem_rsp_data, pcq_head}), .rdata(ibuf_head), .count(ibuf_count),
    .full(ibuf_full), .empty(ibuf_empty)
  );
  assign unused_ok = ^{ibuf_full, pcq_full, pcq_empty};
  assign bus.if_valid = !ibuf_empty;
  assign bus.if_instruction = ibuf_empty ? NOP_INSTR : ibuf_head[ILEN+XLEN-1:XLEN];
  assign bus.if_pc = ibuf_empty ? '0 : ibuf_head[XLEN-1:0];
  assign fetch_fault = state_q == FAULT;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_flushed_q, perf_flushed_d;
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_flushed_d = redirect_valid ? perf_flushed_q + 32'(ibuf_count) + 32'(pcq_count) - 32'(pop)
                                    : perf_flushed_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end
  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + random checks of fetch_stage against a sequential-PC stream model and in-order memory model
module tb_fetch_stage;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic fetch_fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  fetch_stage_if #(.XLEN(32)) bus ();
  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    int due;
  } req_t;
  req_t mq[$];
  int cyc, last_due, lat_lo, lat_hi, n_asrt, n_fail, live;
  logic [31:0] exp_pc, req_pc, s_pop_pc, m_fetched, m_flushed;
  bit mfault, s_if_valid, s_req_valid, s_pop, s_fault;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2] ^ 30'h15A5_3C3C, 2'b11};
  endfunction
  function automatic bit rsp_due();
    return mq.size() > 0 && mq[0].due <= cyc;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input bit rdy, input bit mrdy, input bit rdr = 1'b0, input logic [31:0] rpc = '0);
    @(negedge clk);
    bus.if_ready = rdy;
    bus.imem_req_ready = mrdy;
    redirect_valid = rdr;
    redirect_pc = rpc;
    bus.imem_rsp_valid = rsp_due();
    bus.imem_rsp_data = rsp_due() ? mem_word(mq[0].addr) : $urandom;
    #1;
    s_fault = fetch_fault;
    s_if_valid = bus.if_valid;
    s_req_valid = bus.imem_req_valid;
    s_pop = bus.if_valid && rdy;
    check("fault", fetch_fault, mfault);
    if (rdr || mfault) check("req_idle", bus.imem_req_valid, 0);
    if (s_pop) begin
      s_pop_pc = bus.if_pc;
      check("pop_in_fault", mfault, 0);
      check("if_pc", bus.if_pc, exp_pc);
      check("if_instr", bus.if_instruction, mem_word(exp_pc));
      exp_pc += 4;
      m_fetched++;
      live--;
    end
    if (bus.imem_rsp_valid) void'(mq.pop_front());
    if (bus.imem_req_valid && mrdy) begin
      check("req_addr", bus.imem_req_addr, req_pc);
      req_pc += 4;
      last_due = (cyc + int'($urandom_range(lat_hi, lat_lo)) > last_due + 1) ? cyc + int'($urandom_range(lat_hi, lat_lo)) : last_due + 1;
      if (last_due <= cyc) last_due = cyc + 1;
      mq.push_back('{bus.imem_req_addr, last_due});
      live++;
    end
    if (rdr) begin
      m_flushed += 32'(live);
      live = 0;
      exp_pc = rpc;
      req_pc = rpc;
      mfault = rpc[1:0] != 2'b00;
    end
    @(posedge clk);
    cyc++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.if_ready = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mq.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_instr", bus.if_instruction, 32'h0000_0013);
    check("rst_pc", bus.if_pc, 0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 0);
    check("rst_perf_flushed", perf_flushed, 0);
`endif
    rst = 1'b0;
    cyc = 0;
    last_due = -1;
    exp_pc = '0;
    req_pc = '0;
    mfault = 1'b0;
    live = 0;
    m_fetched = '0;
    m_flushed = '0;
  endtask
  task automatic wait_pop(input string tag, input logic [31:0] pc);
    bit found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      cycle(1, 1);
      found = s_pop;
    end
    check({tag, "_seen"}, found, 1);
    check({tag, "_first_pc"}, s_pop_pc, pc);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int r;
    bit found;
    logic [31:0] rpc;
    n_asrt = 0;
    n_fail = 0;
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1, 1);
      check("t1_valid", s_if_valid, k >= 2);
    end
    repeat (10) cycle(0, 1);
    check("t2_req_idle", s_req_valid, 0);
    check("t2_valid", s_if_valid, 1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0);
      n += int'(s_pop);
    end
    check("t2_buffered", n, DEPTH);
    lat_lo = 3;
    lat_hi = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mq.size() == 2) found = 1'b1;
      else cycle(1, 1);
    end
    check("t3_inflight", found, 1);
    cycle(1, 1, 1'b1, 32'h100);
    cycle(1, 1);
    check("t3_flushed", s_if_valid, 0);
    wait_pop("t3", 32'h100);
    lat_lo = 2;
    lat_hi = 2;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (rsp_due()) found = 1'b1;
      else cycle(1, 1);
    end
    check("t4_rsp_due", found, 1);
    cycle(1, 1, 1'b1, 32'h40);
    cycle(1, 1);
    check("t4_empty", s_if_valid, 0);
    wait_pop("t4", 32'h40);
    cycle(1, 1, 1'b1, 32'h102);
    cycle(1, 1);
    check("t5_fault", s_fault, 1);
    for (int k = 0; k < 8; k++) begin
      cycle(1, 1);
      check("t5_no_req", s_req_valid, 0);
      check("t5_no_valid", s_if_valid, 0);
    end
    cycle(1, 1, 1'b1, 32'h200);
    cycle(1, 1);
    check("t5_cleared", s_fault, 0);
    wait_pop("t5", 32'h200);
    lat_lo = 1;
    lat_hi = 4;
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(99, 0));
      rpc = 32'($urandom_range(255, 0)) << 2;
      if (r == 0) rpc = rpc | 32'd2;
      cycle($urandom_range(2, 0) != 0, $urandom_range(3, 0) != 0, r < 3, rpc);
`ifdef FETCH_PERF_EN
      if (k % 100 == 99) begin
        #1;
        check("t6_perf_fetched", perf_fetched, m_fetched);
        check("t6_perf_flushed", perf_flushed, m_flushed);
      end
`endif
    end
    cycle(1, 1, 1'b1, 32'h300);
    wait_pop("t6", 32'h300);
`ifdef FETCH_PERF_EN
    #1;
    check("t6_perf_fetched_end", perf_fetched, m_fetched);
    check("t6_perf_flushed_end", perf_flushed, m_flushed);
`endif
    lat_lo = 3;
    lat_hi = 3;
    repeat (5) cycle(1, 1);
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    wait_pop("t7", 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
